// File: rtl/rgb_led_pkg.sv
// Shared types for the LED colour pipeline: HSL->RGB converter states and hue sector codes.
package rgb_led_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SECT   = 3'd1,
    CHROMA = 3'd2,
    XM     = 3'd3,
    ASSM   = 3'd4,
    SEND   = 3'd5
  } hsl_state_t;

  // Hue sectors, named <channel carrying C>_<channel carrying X>
  localparam logic [2:0] SECT_R_X = 3'd0;
  localparam logic [2:0] SECT_G_R = 3'd1;
  localparam logic [2:0] SECT_G_B = 3'd2;
  localparam logic [2:0] SECT_B_G = 3'd3;
  localparam logic [2:0] SECT_B_R = 3'd4;
  localparam logic [2:0] SECT_R_B = 3'd5;

endpackage

// File: rtl/hsl_to_rgb_axi4s.sv
// Multi-cycle AXI4-Stream stage converting {L,S,H} to {B,G,R}; one word in flight, TID forwarded.
//
// state  | meaning
// IDLE   | i_tready high, waiting for an HSL word
// SECT   | hue sector / fraction, doubled-lightness term
// CHROMA | C = (dL*S) >> W
// XM     | X from sector fraction, m = L - C/2
// ASSM   | sector mux, add m, saturate, load output regs
// SEND   | o_tvalid high, hold until o_tready
module hsl_to_rgb_axi4s
  import rgb_led_pkg::*;
#(
  parameter int COLOR_WIDTH_P   = 8,
  parameter int TID_BIT_WIDTH_P = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axi4s_i_tvalid,
  output logic                         axi4s_i_tready,
  input  logic [3*COLOR_WIDTH_P-1:0]   axi4s_i_tdata,
  input  logic [TID_BIT_WIDTH_P-1:0]   axi4s_i_tid,
  output logic                         axi4s_o_tvalid,
  input  logic                         axi4s_o_tready,
  output logic [3*COLOR_WIDTH_P-1:0]   axi4s_o_tdata,
  output logic [TID_BIT_WIDTH_P-1:0]   axi4s_o_tid
);

  localparam int W = COLOR_WIDTH_P;
  localparam logic [W-1:0] FULL = '1;

  hsl_state_t                  state_q, state_d;
  logic [W-1:0]                h_q, s_q, l_q;
  logic [TID_BIT_WIDTH_P-1:0]  tid_q;
  logic [2:0]                  sector_q;
  logic [W-1:0]                f_q, dl_q, c_q, x_q, m_q;
  logic                        tready_q, tready_d;
  logic                        tvalid_q, tvalid_d;
  logic [3*W-1:0]              tdata_q, tdata_d;
  logic [TID_BIT_WIDTH_P-1:0]  otid_q;

  logic                        accept;
  logic [W+2:0]                h6;
  logic [2:0]                  sector_safe;
  logic [W-1:0]                dl;
  logic [W-1:0]                ff;
  logic [W-1:0]                r_c, g_c, b_c;
  logic [W:0]                  r_sum, g_sum, b_sum;
  logic [W-1:0]                r_sat, g_sat, b_sat;

  assign accept = axi4s_i_tvalid && tready_q;

  assign h6          = (W+3)'(h_q) * (W+3)'(6);
  // h6 < 6*2^W, so sectors 6/7 cannot occur; map them to sector 0 anyway
  assign sector_safe = (h6[W+2:W] > SECT_R_B) ? SECT_R_X : h6[W+2:W];
  // 2*(FULL-L) == 2*~L, and ~L < 2^(W-1) whenever L's MSB is set
  assign dl          = l_q[W-1] ? {~l_q[W-2:0], 1'b0} : {l_q[W-2:0], 1'b0};
  assign ff          = sector_q[0] ? ~f_q : f_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SECT;
      SECT:    state_d = CHROMA;
      CHROMA:  state_d = XM;
      XM:      state_d = ASSM;
      ASSM:    state_d = SEND;
      SEND:    if (axi4s_o_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_c = c_q;
    g_c = x_q;
    b_c = '0;
    case (sector_q)
      SECT_G_R: begin r_c = x_q; g_c = c_q; b_c = '0;  end
      SECT_G_B: begin r_c = '0;  g_c = c_q; b_c = x_q; end
      SECT_B_G: begin r_c = '0;  g_c = x_q; b_c = c_q; end
      SECT_B_R: begin r_c = x_q; g_c = '0;  b_c = c_q; end
      SECT_R_B: begin r_c = c_q; g_c = '0;  b_c = x_q; end
      default:  begin r_c = c_q; g_c = x_q; b_c = '0;  end
    endcase
    r_sum    = {1'b0, r_c} + {1'b0, m_q};
    g_sum    = {1'b0, g_c} + {1'b0, m_q};
    b_sum    = {1'b0, b_c} + {1'b0, m_q};
    r_sat    = r_sum[W] ? FULL : r_sum[W-1:0];
    g_sat    = g_sum[W] ? FULL : g_sum[W-1:0];
    b_sat    = b_sum[W] ? FULL : b_sum[W-1:0];
    tdata_d  = {b_sat, g_sat, r_sat};
    tready_d = (state_d == IDLE);
    tvalid_d = (state_d == SEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h_q      <= '0;
      s_q      <= '0;
      l_q      <= '0;
      tid_q    <= '0;
      sector_q <= '0;
      f_q      <= '0;
      dl_q     <= '0;
      c_q      <= '0;
      x_q      <= '0;
      m_q      <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      otid_q   <= '0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      if (accept) begin
        h_q   <= axi4s_i_tdata[W-1:0];
        s_q   <= axi4s_i_tdata[2*W-1:W];
        l_q   <= axi4s_i_tdata[3*W-1:2*W];
        tid_q <= axi4s_i_tid;
      end
      case (state_q)
        SECT: begin
          sector_q <= sector_safe;
          f_q      <= h6[W-1:0];
          dl_q     <= dl;
        end
        CHROMA: c_q <= W'(({{W{1'b0}}, dl_q} * {{W{1'b0}}, s_q}) >> W);
        XM: begin
          x_q <= W'(({{W{1'b0}}, c_q} * {{W{1'b0}}, ff}) >> W);
          m_q <= l_q - (c_q >> 1);
        end
        ASSM: begin
          tdata_q <= tdata_d;
          otid_q  <= tid_q;
        end
        default: ;
      endcase
    end
  end

  assign axi4s_i_tready = tready_q;
  assign axi4s_o_tvalid = tvalid_q;
  assign axi4s_o_tdata  = tdata_q;
  assign axi4s_o_tid    = otid_q;

endmodule

// File: tb/tb_hsl_to_rgb_axi4s.sv
// Directed-vector bench for hsl_to_rgb_axi4s (W=8): table of conversions plus stall, streaming and reset sequences.
module tb_hsl_to_rgb_axi4s;

  typedef struct {
    logic [7:0]  h;
    logic [7:0]  s;
    logic [7:0]  l;
    logic        tid;
    logic [23:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [23:0] i_tdata = '0;
  logic [0:0]  i_tid = '0;
  logic        o_tvalid;
  logic        o_tready = 1'b0;
  logic [23:0] o_tdata;
  logic [0:0]  o_tid;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  hsl_to_rgb_axi4s #(.COLOR_WIDTH_P(8), .TID_BIT_WIDTH_P(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .axi4s_i_tvalid (i_tvalid),
    .axi4s_i_tready (i_tready),
    .axi4s_i_tdata  (i_tdata),
    .axi4s_i_tid    (i_tid),
    .axi4s_o_tvalid (o_tvalid),
    .axi4s_o_tready (o_tready),
    .axi4s_o_tdata  (o_tdata),
    .axi4s_o_tid    (o_tid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input vec_t v);
    i_tdata  = {v.l, v.s, v.h};
    i_tid    = v.tid;
    i_tvalid = 1'b1;
  endtask

  // Drive one word, check accept, 4-cycle latency, data, tid, and valid drop after handshake.
  task automatic run_one(input vec_t v, input string tag);
    int n;
    int lat;
    o_tready = 1'b1;
    present(v);
    n = 0;
    while (!i_tready && n < 20) begin tick(); n++; end
    check({tag, "_accept"}, 32'(i_tready), 32'd1);
    tick();
    i_tvalid = 1'b0;
    lat = 0;
    while (!o_tvalid && lat < 20) begin tick(); lat++; end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_data"}, 32'(o_tdata), 32'(v.exp));
    check({tag, "_tid"}, 32'(o_tid), 32'(v.tid));
    tick();
    check({tag, "_valid_drop"}, 32'(o_tvalid), 32'd0);
    check({tag, "_data_hold"}, 32'(o_tdata), 32'(v.exp));
  endtask

  initial begin
    int lat;
    int n;
    bit stable;
    int idx_in;
    int idx_out;
    int last_acc;
    bit acc;
    bit outv;

    vecs[0] = '{8'h00, 8'hFF, 8'h80, 1'b0, 24'h0202FF};
    vecs[1] = '{8'h55, 8'hFF, 8'h80, 1'b1, 24'h02FF02};
    vecs[2] = '{8'hFF, 8'hFF, 8'h80, 1'b0, 24'h0602FF};
    vecs[3] = '{8'h37, 8'h00, 8'hC8, 1'b1, 24'hC8C8C8};
    vecs[4] = '{8'hA0, 8'hFF, 8'h00, 1'b0, 24'h000000};
    vecs[5] = '{8'hAA, 8'hFF, 8'h80, 1'b1, 24'hFF0402};
    vecs[6] = '{8'h2A, 8'h80, 8'h40, 1'b0, 24'h205F60};
    vecs[7] = '{8'h80, 8'hFF, 8'hFF, 1'b1, 24'hFFFFFF};
    vecs[8] = '{8'h60, 8'hFF, 8'h80, 1'b0, 24'h41FF02};
    vecs[9] = '{8'hC0, 8'hFF, 8'h80, 1'b1, 24'hFF0280};

    // reset values and i_tready rise one cycle after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 32'(i_tready), 32'd0);
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tdata", 32'(o_tdata), 32'd0);
    check("rst_tid", 32'(o_tid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("tready_before_edge", 32'(i_tready), 32'd0);
    @(posedge clk);
    #1;
    check("tready_post_reset", 32'(i_tready), 32'd1);

    for (int i = 0; i < 10; i++)
      run_one(vecs[i], $sformatf("vec%0d", i));

    // consumer stall in SEND with a second word waiting
    o_tready = 1'b0;
    present(vecs[0]);
    n = 0;
    while (!i_tready && n < 20) begin tick(); n++; end
    check("stall_accept", 32'(i_tready), 32'd1);
    tick();
    present(vecs[1]);
    lat = 0;
    while (!o_tvalid && lat < 20) begin tick(); lat++; end
    check("stall_latency", 32'(lat), 32'd4);
    check("stall_tready_low", 32'(i_tready), 32'd0);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_tvalid !== 1'b1 || o_tdata !== vecs[0].exp || i_tready !== 1'b0) stable = 1'b0;
    end
    check("stall_hold_stable", 32'(stable), 32'd1);
    check("stall_data", 32'(o_tdata), 32'(vecs[0].exp));
    o_tready = 1'b1;
    tick();
    check("stall_valid_drop", 32'(o_tvalid), 32'd0);
    check("stall_tready_after_hs", 32'(i_tready), 32'd1);
    tick();
    i_tvalid = 1'b0;
    lat = 0;
    while (!o_tvalid && lat < 20) begin tick(); lat++; end
    check("stall_second_latency", 32'(lat), 32'd4);
    check("stall_second_data", 32'(o_tdata), 32'(vecs[1].exp));
    check("stall_second_tid", 32'(o_tid), 32'(vecs[1].tid));
    tick();

    // i_tvalid held high: accept every 6 cycles, outputs in order
    o_tready = 1'b1;
    idx_in   = 0;
    idx_out  = 0;
    last_acc = -1;
    present(vecs[2]);
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc  = i_tvalid && i_tready;
      outv = o_tvalid && o_tready;
      if (outv) begin
        if (idx_out < 3) begin
          check($sformatf("stream_data%0d", idx_out), 32'(o_tdata), 32'(vecs[2 + idx_out].exp));
          check($sformatf("stream_tid%0d", idx_out), 32'(o_tid), 32'(vecs[2 + idx_out].tid));
        end
        idx_out++;
      end
      tick();
      if (acc) begin
        if (last_acc >= 0)
          check($sformatf("stream_gap%0d", idx_in), 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        idx_in++;
        if (idx_in < 3) present(vecs[2 + idx_in]);
        else i_tvalid = 1'b0;
      end
    end
    check("stream_out_count", 32'(idx_out), 32'd3);

    // reset pulsed while the word sits in CHROMA
    run_one(vecs[1], "pre_rst");
    present(vecs[2]);
    tick();
    i_tvalid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tready", 32'(i_tready), 32'd0);
    check("midrst_tvalid", 32'(o_tvalid), 32'd0);
    check("midrst_tdata", 32'(o_tdata), 32'd0);
    check("midrst_tid", 32'(o_tid), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("midrst_tready_rise", 32'(i_tready), 32'd1);
    check("midrst_no_output", 32'(o_tvalid), 32'd0);
    run_one(vecs[9], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
